// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target with a small register file. It answers its own 7-bit address,
// accepts a register pointer followed by any number of data bytes, and
// serves reads (normally after a repeated START). The pointer auto-increments
// and wraps modulo NUM_REGS. SCL and SDA are oversampled on clk_4MHz, which
// must run at least 16x the SCL rate. SDA is open-drain: sda_oe=1 pulls it low.
//
// Parameters:
//   DEV_ADDR  7-bit address this target answers
//   NUM_REGS  register count, power of two in 2..16
//   PTR_W     pointer width, derived from NUM_REGS
//
// Ports:
//   clk_4MHz  system clock
//   rst       asynchronous, active-high reset
//   scl_i     raw SCL from the pad
//   sda_i     raw SDA from the pad
//   sda_oe    1 = pull SDA low, 0 = release
//   selected  high from our address ACK until STOP, START or a read NACK
//   wr_stb    one-cycle pulse per register written
//   wr_addr   register index belonging to wr_stb
//   wr_data   byte belonging to wr_stb
//   reg_q     register file, register i at [8i+7:8i]
//
// Build option:
//   GLITCH_FILTER_EN  when defined, a 3-sample majority filter follows each
//                     synchronizer so single-cycle pulses on SCL/SDA are
//                     rejected, at the cost of one extra cycle of latency.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NUM_REGS = 4,
    localparam int        PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk_4MHz,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  selected,
    output logic                  wr_stb,
    output logic [PTR_W-1:0]      wr_addr,
    output logic [7:0]            wr_data,
    output logic [8*NUM_REGS-1:0] reg_q
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK
    } state_t;

    logic [1:0]       scl_sync;
    logic [1:0]       sda_sync;
    logic             scl_cur;
    logic             sda_cur;
    logic             scl_prev;
    logic             sda_prev;
    logic             scl_rise;
    logic             scl_fall;
    logic             start_cond;
    logic             stop_cond;
    logic [7:0]       rx_byte;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic             ack_hi;
    logic             rw;
    logic [7:0]       shift;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       regs [NUM_REGS];

    // Two-flop synchronizers for the pad inputs. They reset to 1 (idle bus)
    // so coming out of reset never looks like an edge.
    always_ff @(posedge clk_4MHz or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    // Two older samples per line; together with the newest synchronized
    // sample they form the majority vote, which hides one-cycle pulses.
    always_ff @(posedge clk_4MHz or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    assign scl_cur = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                     (scl_hist[0] & scl_hist[1]);
    assign sda_cur = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                     (sda_hist[0] & sda_hist[1]);
`else
    assign scl_cur = scl_sync[1];
    assign sda_cur = sda_sync[1];
`endif

    // Previous-sample register used for edge and START/STOP detection.
    always_ff @(posedge clk_4MHz or posedge rst) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    assign scl_rise   = scl_cur & ~scl_prev;
    assign scl_fall   = ~scl_cur & scl_prev;
    assign start_cond = scl_cur & scl_prev & sda_prev & ~sda_cur;
    assign stop_cond  = scl_cur & scl_prev & ~sda_prev & sda_cur;

    // The byte as it will look once the bit on the bus right now is shifted in.
    assign rx_byte = {shift[6:0], sda_cur};

    // Protocol state machine plus the register file. START/STOP take priority
    // over bit handling. ACKs span two SCL falls: the first pulls SDA low, the
    // second releases it (and, entering a read, puts out the first data bit).
    always_ff @(posedge clk_4MHz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            ack_hi    <= 1'b0;
            rw        <= 1'b0;
            shift     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            selected  <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_stb <= 1'b0;
            if (start_cond || stop_cond) begin
                state     <= start_cond ? ADDR : IDLE;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                ack_hi    <= 1'b0;
                sda_oe    <= 1'b0;
                selected  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ADDR, REG, WRITE: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        rw    <= rx_byte[0];
                                        state <= ADDR_ACK;
                                    end else begin
                                        state <= IDLE;
                                    end
                                end else if (state == REG) begin
                                    ptr   <= rx_byte[PTR_W-1:0];
                                    state <= REG_ACK;
                                end else begin
                                    regs[ptr] <= rx_byte;
                                    wr_stb    <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= rx_byte;
                                    ptr       <= ptr + PTR_W'(1);
                                    state     <= WRITE_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!ack_hi) begin
                                ack_hi   <= 1'b1;
                                sda_oe   <= 1'b1;
                                selected <= 1'b1;
                            end else begin
                                ack_hi  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    shift     <= regs[ptr];
                                    sda_oe    <= ~regs[ptr][7];
                                    byte_done <= 1'b0;
                                    state     <= READ;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ADDR_ACK) ? REG : WRITE;
                                end
                            end
                        end
                    end
                    READ: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                sda_oe    <= 1'b0;
                                byte_done <= 1'b0;
                                bit_cnt   <= '0;
                                ptr       <= ptr + PTR_W'(1);
                                state     <= READ_ACK;
                            end else begin
                                sda_oe <= ~shift[3'd7 - bit_cnt];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (!sda_cur) begin
                                shift     <= regs[ptr];
                                bit_cnt   <= '0;
                                byte_done <= 1'b0;
                                state     <= READ;
                            end else begin
                                sda_oe   <= 1'b0;
                                selected <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
        assign reg_q[8*gi +: 8] = regs[gi];
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bench for i2c_target_regs (DEV_ADDR=0x50, NUM_REGS=4). A simple bit-banged
// master drives SCL and SDA; SDA is a wired-AND of the master and the
// target's open-drain output. SCL runs at 1/20 of clk_4MHz.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

    localparam int Q = 5;

    logic        clk_4MHz = 1'b0;
    logic        rst      = 1'b1;
    logic        scl_m    = 1'b1;
    logic        sda_m    = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic        selected;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [31:0] reg_q;

    int          test_cnt = 0;
    int          fail_cnt = 0;
    int          oe_cnt   = 0;
    int          sel_cnt  = 0;
    logic [9:0]  wr_queue [$];
    logic [7:0]  rd_queue [$];

    always #125 clk_4MHz = ~clk_4MHz;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regs dut (
        .clk_4MHz (clk_4MHz),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .selected (selected),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .reg_q    (reg_q)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Set both master lines, then hold them for a quarter SCL period.
    task automatic applyStimulus(input logic scl, input logic sda);
        @(negedge clk_4MHz);
        scl_m = scl;
        sda_m = sda;
        repeat (Q - 1) @(negedge clk_4MHz);
    endtask

    task automatic i2c_start();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic i2c_stop();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        applyStimulus(1'b0, b);
        applyStimulus(1'b1, b);
        applyStimulus(1'b1, b);
        applyStimulus(1'b0, b);
    endtask

    // One-cycle SCL high pulse while SCL is otherwise low; SDA untouched.
    task automatic inject_glitch();
        @(negedge clk_4MHz);
        scl_m = 1'b1;
        @(negedge clk_4MHz);
        scl_m = 1'b0;
        repeat (3) @(negedge clk_4MHz);
    endtask

    // Eight data bits, optionally with a glitch after glitch_after bits,
    // then the ACK clock; acked reports whether SDA was low mid-high.
    task automatic send_byte(input logic [7:0] b, input int glitch_after, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (glitch_after != 0 && (8 - i) == glitch_after) inject_glitch();
        end
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        acked = ~sda_bus;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1);
            b[i] = sda_bus;
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
        end
        send_bit(~master_ack);
    endtask

    // Every write strobe must match the oldest expected (addr, data) pair.
    always @(negedge clk_4MHz) begin
        if (sda_oe) oe_cnt++;
        if (selected) sel_cnt++;
        if (wr_stb) begin
            if (wr_queue.size() == 0) begin
                checkOutput("wr_stb_unexpected", {31'd0, wr_stb}, 32'd0);
            end else begin
                checkOutput("wr_stb_addr_data", {22'd0, wr_addr, wr_data},
                            {22'd0, wr_queue.pop_front()});
            end
        end
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #(10_000_000);
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence: reset, write, read with Sr, foreign address, pointer
    // wrap, aborted write, reset during ACK, SCL glitch.
    initial begin
        logic       ack;
        logic [7:0] rd;
        int         oe_base;
        int         sel_base;
        logic [7:0] glitch_exp;
        logic       glitch_ack;

        repeat (4) @(negedge clk_4MHz);
        checkOutput("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("reset_selected", {31'd0, selected}, 32'd0);
        checkOutput("reset_wr_stb", {31'd0, wr_stb}, 32'd0);
        checkOutput("reset_wr_addr", {30'd0, wr_addr}, 32'd0);
        checkOutput("reset_wr_data", {24'd0, wr_data}, 32'd0);
        checkOutput("reset_reg_q", reg_q, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_4MHz);

        // Write pointer 1, then 0xA5 and 0x3C.
        i2c_start();
        send_byte(8'hA0, 0, ack);
        checkOutput("write_addr_ack", {31'd0, ack}, 32'd1);
        checkOutput("write_selected", {31'd0, selected}, 32'd1);
        send_byte(8'h01, 0, ack);
        checkOutput("write_ptr_ack", {31'd0, ack}, 32'd1);
        wr_queue.push_back({2'd1, 8'hA5});
        send_byte(8'hA5, 0, ack);
        checkOutput("write_data0_ack", {31'd0, ack}, 32'd1);
        wr_queue.push_back({2'd2, 8'h3C});
        send_byte(8'h3C, 0, ack);
        checkOutput("write_data1_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);
        checkOutput("write_reg_q", reg_q, 32'h003C_A500);
        checkOutput("write_selected_after_stop", {31'd0, selected}, 32'd0);

        // Pointer 2, repeated START, read two bytes (ACK then NACK).
        i2c_start();
        send_byte(8'hA0, 0, ack);
        checkOutput("read_addrw_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h02, 0, ack);
        checkOutput("read_ptr_ack", {31'd0, ack}, 32'd1);
        i2c_start();
        send_byte(8'hA1, 0, ack);
        checkOutput("read_addrr_ack", {31'd0, ack}, 32'd1);
        checkOutput("read_selected", {31'd0, selected}, 32'd1);
        rd_queue.push_back(8'h3C);
        recv_byte(1'b1, rd);
        checkOutput("read_byte0", {24'd0, rd}, {24'd0, rd_queue.pop_front()});
        rd_queue.push_back(8'h00);
        recv_byte(1'b0, rd);
        checkOutput("read_byte1", {24'd0, rd}, {24'd0, rd_queue.pop_front()});
        checkOutput("read_release_after_nack", {31'd0, sda_oe}, 32'd0);
        checkOutput("read_selected_after_nack", {31'd0, selected}, 32'd0);
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);

        // Foreign address 0x51: no ACK, no drive, never selected.
        oe_base  = oe_cnt;
        sel_base = sel_cnt;
        i2c_start();
        send_byte(8'hA2, 0, ack);
        checkOutput("mismatch_addr_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h11, 0, ack);
        send_byte(8'h22, 0, ack);
        send_byte(8'h33, 0, ack);
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);
        checkOutput("mismatch_oe_cycles", oe_cnt - oe_base, 32'd0);
        checkOutput("mismatch_sel_cycles", sel_cnt - sel_base, 32'd0);
        checkOutput("mismatch_reg_q", reg_q, 32'h003C_A500);

        // Pointer 3 wraps to 0; pointer 0x07 maps to register 3.
        i2c_start();
        send_byte(8'hA0, 0, ack);
        send_byte(8'h03, 0, ack);
        wr_queue.push_back({2'd3, 8'h11});
        send_byte(8'h11, 0, ack);
        wr_queue.push_back({2'd0, 8'h22});
        send_byte(8'h22, 0, ack);
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);
        checkOutput("wrap_reg_q", reg_q, 32'h113C_A522);
        i2c_start();
        send_byte(8'hA0, 0, ack);
        send_byte(8'h07, 0, ack);
        checkOutput("wide_ptr_ack", {31'd0, ack}, 32'd1);
        wr_queue.push_back({2'd3, 8'h44});
        send_byte(8'h44, 0, ack);
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);
        checkOutput("wide_ptr_reg_q", reg_q, 32'h443C_A522);

        // STOP after four data bits: partial byte dropped.
        i2c_start();
        send_byte(8'hA0, 0, ack);
        send_byte(8'h01, 0, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);
        checkOutput("abort_reg_q", reg_q, 32'h443C_A522);
        checkOutput("abort_selected", {31'd0, selected}, 32'd0);

        // Reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(rd_bit(8'hA0, i));
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ack_oe_before_rst", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("rst_selected", {31'd0, selected}, 32'd0);
        checkOutput("rst_reg_q", reg_q, 32'd0);
        checkOutput("rst_wr_addr_data", {22'd0, wr_addr, wr_data}, 32'd0);
        applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        repeat (4) @(negedge clk_4MHz);

        // One-cycle SCL pulse after four bits of 0x96 (bit 4 = 1 on the bus).
`ifdef GLITCH_FILTER_EN
        glitch_exp = 8'h96;
        glitch_ack = 1'b1;
`else
        glitch_exp = 8'h9B;
        glitch_ack = 1'b0;
`endif
        i2c_start();
        send_byte(8'hA0, 0, ack);
        send_byte(8'h00, 0, ack);
        wr_queue.push_back({2'd0, glitch_exp});
        send_byte(8'h96, 4, ack);
        checkOutput("glitch_ack", {31'd0, ack}, {31'd0, glitch_ack});
        i2c_stop();
        repeat (4) @(negedge clk_4MHz);
        checkOutput("glitch_reg_q", reg_q, {24'd0, glitch_exp});

        checkOutput("wr_queue_drained", wr_queue.size(), 32'd0);
        checkOutput("rd_queue_drained", rd_queue.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] b, input int i);
        return b[i];
    endfunction

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (slave) that answers the I2C master's write and read transactions: write with register pointer, and register read after a repeated START. It holds a small register file, ACKs its own 7-bit address, auto-increments the pointer, and exposes register contents and write strobes to fabric. Both bus lines are oversampled on the system clock. SDA is driven open-drain via an output-enable.

Parameters:
DEV_ADDR, 7'h50, 7-bit target address matched after START
NUM_REGS, 4, register count; power of 2, 2..16
PTR_W, $clog2(NUM_REGS), pointer width (derived, not overridden)

Ports:
clk_4MHz  input  1  system clock; must be >= 16x SCL frequency
rst  input  1  asynchronous, active-high reset
scl_i  input  1  raw SCL from pad
sda_i  input  1  raw SDA from pad
sda_oe  output  1  1 = pull SDA low, 0 = release
selected  output  1  high from address ACK until STOP/START/NACK-abort
wr_stb  output  1  one-cycle pulse per register written
wr_addr  output  PTR_W  register index of current wr_stb
wr_data  output  8  byte of current wr_stb
reg_q  output  8*NUM_REGS  register file, reg i at [8i+7:8i]

Behaviour:
- Reset (async, immediate): sda_oe=0, selected=0, wr_stb=0, wr_addr=0, wr_data=0, all regs=0, ptr=0, state=IDLE.
- Input path: 2-flop synchronizer on scl_i and sda_i, then a previous-sample register. Rise/fall detected from the synchronized vs previous sample.
- START: SDA falls while SCL high (current and previous). Valid in any state -> ADDR, bit_cnt=0, sda_oe=0, selected=0. Covers repeated START.
- STOP: SDA rises while SCL high. Valid in any state -> IDLE, sda_oe=0, selected=0. A partial byte is discarded.
- Data is sampled on SCL rise. The target changes sda_oe only on the cycle after SCL fall is detected.
- Bytes are MSB first. bit_cnt runs 0..7.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits. On 8th rise, if byte[7:1]==DEV_ADDR -> ADDR_ACK and latch rw=byte[0]; else -> IDLE with sda_oe never asserted.
  - ADDR_ACK: next SCL fall sets sda_oe=1 and selected=1. The following fall sets sda_oe=0. Then rw=0 -> REG; rw=1 -> READ, load shift from reg[ptr] and drive bit7 on that same fall.
  - REG: 8 bits. On 8th rise, ptr <= byte[PTR_W-1:0] (upper bits ignored, always ACKed) -> REG_ACK -> WRITE. ACK timing is identical to ADDR_ACK.
  - WRITE: 8 bits. On 8th rise: reg[ptr] <= byte; wr_stb=1 for exactly one cycle with wr_addr=ptr and wr_data=byte; ptr <= ptr+1 mod NUM_REGS -> WRITE_ACK -> WRITE.
  - READ: on each SCL fall drive sda_oe = ~shift[7-bit_cnt]. After the 8th bit's fall, release. ptr <= ptr+1 mod NUM_REGS -> READ_ACK.
  - READ_ACK: sample SDA on rise. If 0 (master ACK), load shift from reg[ptr] and drive its bit7 on the next fall -> READ. If 1 (NACK), go to IDLE and wait for STOP/START.
- The register loaded for a read is captured at load time; a later wr_stb does not alter the byte in flight.
- START and STOP are checked before bit sampling in the same cycle.
- rst mid-ACK or mid-read releases SDA combinationally-free: sda_oe comes from a flop that is async-cleared.

Optional Feature:
GLITCH_FILTER_EN: when defined, a 3-sample majority filter sits after each synchronizer, so SCL/SDA pulses of 1 clk_4MHz cycle are rejected. This adds 1 cycle of edge latency. When undefined, synchronized samples are used directly, and a 1-cycle pulse is a valid edge.

Test Plan:
- Write: START, 0xA0 (0x50 W), 0x01, 0xA5, 0x3C, STOP -> 4 ACKs (sda_oe low during each 9th clock); wr_stb pulses (1,0xA5) then (2,0x3C); reg_q = 0x3C_A5_00 in bytes 2..0.
- Read with repeated START, continuing from the prior state: START, 0xA0, 0x02, Sr, 0xA1, read 2 bytes (master ACK, then NACK), STOP -> target drives 0x3C, then 0x00; SDA released after NACK; selected falls; no wr_stb.
- Address mismatch: START, 0xA2 (0x51 W), 3 data bytes, STOP -> sda_oe stays 0 throughout; no wr_stb; selected stays 0.
- Wrap: NUM_REGS=4, write pointer 0x03 then data 0x11, 0x22 -> reg3=0x11, reg0=0x22; wr_addr sequence 3, 0. Pointer byte 0x07 is ACKed and maps to reg3.
- Aborts:
  - STOP after 4 data bits of a write -> no wr_stb; state IDLE; register unchanged.
  - rst asserted while sda_oe=1 during ACK -> sda_oe=0 immediately; regs cleared.
- Glitch: inject a 1-cycle SCL high pulse mid-byte -> with GLITCH_FILTER_EN the byte is received intact; without it bit_cnt advances and the byte is misaligned.
